cv32e40n_apu_requester: RTL and testbench
=========================================

Name: cv32e40n_apu_requester

Overview:
Core-side initiator for the APU request/response protocol.
- Accepts offload operations from the issue stage over a valid/ready handshake.
- Drives apu_req_o and holds the request stable until apu_gnt_i.
- Tracks granted-but-unanswered operations in an in-order tag FIFO of destination register addresses.
- Pairs each apu_rvalid_i response with its destination and presents the result to writeback one cycle later.

Parameters:
NARGS, 3, number of 32-bit operands per request
WOP, 6, operation code width
NDSFLAGS, 15, downstream (request) flag width
NUSFLAGS, 5, upstream (response) flag width
MAX_OUTSTANDING, 4, tag FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  synchronous active-low reset
issue_valid_i  in  1  issue stage presents an operation
issue_ready_o  out  1  operation accepted this cycle when high with issue_valid_i
issue_operands_i  in  NARGS x 32  operands
issue_op_i  in  WOP  operation code
issue_flags_i  in  NDSFLAGS  request flags
issue_waddr_i  in  5  destination register address
apu_req_o  out  1  request to accelerator
apu_gnt_i  in  1  accelerator grant
apu_operands_o  out  NARGS x 32  registered operands
apu_op_o  out  WOP  registered op
apu_flags_o  out  NDSFLAGS  registered flags
apu_rvalid_i  in  1  response valid
apu_result_i  in  32  response data
apu_flags_i  in  NUSFLAGS  response flags
wb_valid_o  out  1  writeback pulse
wb_waddr_o  out  5  destination of writeback
wb_result_o  out  32  result
wb_flags_o  out  NUSFLAGS  response flags
busy_o  out  1  request pending or any operation outstanding
spurious_o  out  1  sticky: response received with nothing outstanding

Behaviour:
- Reset (rst_ni low at rising edge): state=IDLE, count=0, FIFO pointers=0, apu_req_o=0, apu_operands_o/op/flags=0, wb_valid_o=0, wb_waddr_o=0, wb_result_o=0, wb_flags_o=0, spurious_o=0.
- Reset mid-operation drops the request and discards all outstanding tags. Any later response counts as spurious.
- FSM states: IDLE, REQ.
- IDLE:
  - issue_ready_o = (count < MAX_OUTSTANDING); combinational.
  - On issue_valid_i && issue_ready_o: capture operands/op/flags into the apu_* output registers and waddr into a pending-tag register; next state REQ.
- REQ:
  - apu_req_o=1 (registered, asserted the cycle after acceptance). issue_ready_o=0.
  - Request payload is held stable while apu_gnt_i=0; no timeout.
  - On apu_gnt_i: push the pending tag to the FIFO, count+1, next state IDLE. apu_req_o falls the next cycle.
  - Minimum issue spacing is 2 cycles.
- apu_gnt_i while in IDLE is ignored.
- Response:
  - apu_rvalid_i && count>0: pop FIFO head. Next cycle wb_valid_o=1 for exactly one cycle, with wb_waddr_o=head tag, wb_result_o=apu_result_i, wb_flags_o=apu_flags_i. count-1.
  - Responses are in order; there is no writeback backpressure.
  - apu_rvalid_i with count==0: no pop, wb_valid_o stays 0, spurious_o set and held until reset.
- Grant (push) and rvalid (pop) in the same cycle: count unchanged, both FIFO pointers advance. This is legal even when count==MAX_OUTSTANDING, because REQ was only entered with count<MAX.
- wb data registers hold their value when wb_valid_o=0.
- Pointers wrap modulo MAX_OUTSTANDING. count width is clog2(MAX_OUTSTANDING)+1.
- busy_o = (state==REQ) || (count!=0).

Test Plan:
- Single op: issue waddr=5, op=1, operands {1,2,3}, gnt one cycle after req, rvalid 2 cycles later with result 0xDEADBEEF -> apu_req_o high 1 cycle with op=1; wb_valid_o pulse with waddr=5, result 0xDEADBEEF; busy_o low afterwards.
- Grant stall: gnt held low 5 cycles -> apu_req_o high and operands/op/flags unchanged for 6 cycles; issue_ready_o=0 throughout.
- Fill: 4 ops (waddr 1,2,3,4) granted, no responses -> issue_ready_o=0 with count=4. Then 4 rvalids with results 10,20,30,40 -> writebacks in order waddr 1..4 with matching results.
- Simultaneous grant and rvalid with count=3 -> count stays 3; the popped tag is the oldest; a further 8 ops check pointer wraparound.
- Spurious: rvalid with count=0 -> no wb_valid_o, spurious_o=1 and held; reset clears it.
- Reset mid-REQ with 2 outstanding -> apu_req_o=0 the next cycle, busy_o=0; a subsequent rvalid sets spurious_o with no writeback.

Source files
------------

// File: rtl/cv32e40n_apu_requester.sv
// ----------------------------------------------------------------------------
// cv32e40n_apu_requester
//
// Core-side initiator for the APU request/response protocol. An operation
// accepted from the issue stage is registered onto the apu_* request outputs
// and held until the accelerator grants it. Once granted, its destination
// register address is queued in an in-order tag FIFO. Each response pops
// the oldest tag, and the result is presented to writeback one cycle later.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   issue_valid_i/ready_o    issue handshake
//   issue_operands_i/op_i/flags_i/waddr_i   operation payload and destination
//   apu_req_o / apu_gnt_i    request handshake to the accelerator
//   apu_operands_o/op_o/flags_o              registered request payload
//   apu_rvalid_i/result_i/flags_i            accelerator response
//   wb_valid_o/waddr_o/result_o/flags_o      one-cycle writeback pulse
//   busy_o                   request pending or operations outstanding
//   spurious_o               sticky: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module cv32e40n_apu_requester #(
    parameter int unsigned NARGS           = 3,
    parameter int unsigned WOP             = 6,
    parameter int unsigned NDSFLAGS        = 15,
    parameter int unsigned NUSFLAGS        = 5,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [NARGS*32-1:0]   issue_operands_i,
    input  logic [WOP-1:0]        issue_op_i,
    input  logic [NDSFLAGS-1:0]   issue_flags_i,
    input  logic [4:0]            issue_waddr_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [NARGS*32-1:0]   apu_operands_o,
    output logic [WOP-1:0]        apu_op_o,
    output logic [NDSFLAGS-1:0]   apu_flags_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_result_i,
    input  logic [NUSFLAGS-1:0]   apu_flags_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_waddr_o,
    output logic [31:0]           wb_result_o,
    output logic [NUSFLAGS-1:0]   wb_flags_o,
    output logic                  busy_o,
    output logic                  spurious_o
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    typedef enum logic {StIdle, StReq} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [4:0]          tag_fifo_q [MAX_OUTSTANDING];
    logic [4:0]          pend_waddr_q;
    logic [NARGS*32-1:0] operands_q;
    logic [WOP-1:0]      op_q;
    logic [NDSFLAGS-1:0] dsflags_q;
    logic                wb_valid_q;
    logic [4:0]          wb_waddr_q;
    logic [31:0]         wb_result_q;
    logic [NUSFLAGS-1:0] wb_flags_q;
    logic                spurious_q;
    logic                accept, push, pop;

    always_comb begin
        state_d       = state_q;
        issue_ready_o = 1'b0;
        accept        = 1'b0;
        push          = 1'b0;
        case (state_q)
            StIdle: begin
                issue_ready_o = (count_q < MaxCnt);
                accept        = issue_valid_i && issue_ready_o;
                if (accept) state_d = StReq;
            end
            StReq: begin
                push = apu_gnt_i;
                if (apu_gnt_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Responses with nothing outstanding never pop; they only flag spurious.
        pop = apu_rvalid_i && (count_q != '0);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_waddr_q <= '0;
            operands_q   <= '0;
            op_q         <= '0;
            dsflags_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_waddr_q   <= '0;
            wb_result_q  <= '0;
            wb_flags_q   <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wb_valid_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) begin
                operands_q   <= issue_operands_i;
                op_q         <= issue_op_i;
                dsflags_q    <= issue_flags_i;
                pend_waddr_q <= issue_waddr_i;
            end
            if (pop) begin
                wb_waddr_q  <= tag_fifo_q[rd_ptr_q];
                wb_result_q <= apu_result_i;
                wb_flags_q  <= apu_flags_i;
            end
            if (apu_rvalid_i && (count_q == '0)) spurious_q <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) tag_fifo_q[wr_ptr_q] <= pend_waddr_q;
    end

    assign apu_req_o      = (state_q == StReq);
    assign apu_operands_o = operands_q;
    assign apu_op_o       = op_q;
    assign apu_flags_o    = dsflags_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_waddr_o     = wb_waddr_q;
    assign wb_result_o    = wb_result_q;
    assign wb_flags_o     = wb_flags_q;
    assign busy_o         = (state_q == StReq) || (count_q != '0);
    assign spurious_o     = spurious_q;

endmodule

// File: tb/tb_cv32e40n_apu_requester.sv
// ----------------------------------------------------------------------------
// tb_cv32e40n_apu_requester
//
// Directed bench for cv32e40n_apu_requester. A small model keeps the queue of
// granted destination tags; every response pairs a result with the oldest tag
// and pushes the expected writeback to a scoreboard, which a monitor pops and
// compares on each wb_valid_o pulse.
// ----------------------------------------------------------------------------
module tb_cv32e40n_apu_requester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [95:0] issue_operands = '0;
    logic [5:0]  issue_op = '0;
    logic [14:0] issue_flags = '0;
    logic [4:0]  issue_waddr = '0;
    logic        apu_req;
    logic        apu_gnt = 1'b0;
    logic [95:0] apu_operands;
    logic [5:0]  apu_op;
    logic [14:0] apu_flags_ds;
    logic        apu_rvalid = 1'b0;
    logic [31:0] apu_result = '0;
    logic [4:0]  apu_flags_us = '0;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_result;
    logic [4:0]  wb_flags;
    logic        busy;
    logic        spurious;

    int compared = 0;
    int mismatched = 0;

    logic [4:0]  tags[$];
    logic [41:0] sb[$];
    logic [4:0]  pend_tag = '0;
    logic        in_req = 1'b0;
    logic        exp_spur = 1'b0;

    cv32e40n_apu_requester dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_operands_i (issue_operands),
        .issue_op_i       (issue_op),
        .issue_flags_i    (issue_flags),
        .issue_waddr_i    (issue_waddr),
        .apu_req_o        (apu_req),
        .apu_gnt_i        (apu_gnt),
        .apu_operands_o   (apu_operands),
        .apu_op_o         (apu_op),
        .apu_flags_o      (apu_flags_ds),
        .apu_rvalid_i     (apu_rvalid),
        .apu_result_i     (apu_result),
        .apu_flags_i      (apu_flags_us),
        .wb_valid_o       (wb_valid),
        .wb_waddr_o       (wb_waddr),
        .wb_result_o      (wb_result),
        .wb_flags_o       (wb_flags),
        .busy_o           (busy),
        .spurious_o       (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk_ops(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        return {c, b, a};
    endfunction

    // Writeback monitor: each pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", wb_valid, 1'b0);
            end else begin
                logic [41:0] e;
                e = sb.pop_front();
                chk("wb_waddr", wb_waddr, e[41:37]);
                chk("wb_result", wb_result, e[36:5]);
                chk("wb_flags", wb_flags, e[4:0]);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tags.delete();
        in_req   = 1'b0;
        exp_spur = 1'b0;
        chk("rst_req", apu_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_waddr", wb_waddr, 5'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_spurious", spurious, 1'b0);
        chk("rst_op", apu_op, 6'd0);
        chk("rst_operands", apu_operands, 96'd0);
        chk("rst_ready", issue_ready, 1'b1);
    endtask

    task automatic issue(input logic [4:0] wa, input logic [5:0] op, input logic [95:0] ops,
                         input logic [14:0] fl);
        int n = 0;
        while (!issue_ready && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready_wait", issue_ready, 1'b1);
        issue_valid    = 1'b1;
        issue_waddr    = wa;
        issue_op       = op;
        issue_operands = ops;
        issue_flags    = fl;
        tick();
        issue_valid = 1'b0;
        pend_tag    = wa;
        in_req      = 1'b1;
        chk("req_after_accept", apu_req, 1'b1);
        chk("req_op", apu_op, op);
        chk("req_operands", apu_operands, ops);
        chk("req_flags", apu_flags_ds, fl);
    endtask

    // One clock with optional grant and response; updates the tag model.
    task automatic cycle(input logic g, input logic rv, input logic [31:0] res,
                         input logic [4:0] fl);
        logic [4:0] t;
        apu_gnt      = g;
        apu_rvalid   = rv;
        apu_result   = res;
        apu_flags_us = fl;
        if (rv) begin
            if (tags.size() > 0) begin
                t = tags.pop_front();
                sb.push_back({t, res, fl});
            end else begin
                exp_spur = 1'b1;
            end
        end
        if (g && in_req) begin
            tags.push_back(pend_tag);
            in_req = 1'b0;
        end
        tick();
        apu_gnt    = 1'b0;
        apu_rvalid = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();

        // Single operation.
        issue(5'd5, 6'd1, mk_ops(1, 2, 3), 15'h0);
        cycle(1'b1, 1'b0, 0, 0);
        chk("single_req_fall", apu_req, 1'b0);
        chk("single_busy_out", busy, 1'b1);
        tick();
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 5'h3);
        tick();
        chk("single_busy_done", busy, 1'b0);

        // Grant stall: payload held, new issue attempts ignored.
        issue(5'd7, 6'd2, mk_ops(32'hA, 32'hB, 32'hC), 15'h1234);
        for (int i = 0; i < 5; i++) begin
            issue_valid    = 1'b1;
            issue_op       = 6'd9;
            issue_operands = mk_ops(9, 9, 9);
            issue_flags    = 15'h7FFF;
            issue_waddr    = 5'd30;
            chk("stall_ready", issue_ready, 1'b0);
            tick();
            chk("stall_req", apu_req, 1'b1);
            chk("stall_op", apu_op, 6'd2);
            chk("stall_operands", apu_operands, mk_ops(32'hA, 32'hB, 32'hC));
            chk("stall_flags", apu_flags_ds, 15'h1234);
        end
        issue_valid = 1'b0;
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 32'h1111, 5'h1);
        tick();

        // Fill to capacity, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i), 6'd3, mk_ops(i, i, i), 15'h0);
            cycle(1'b1, 1'b0, 0, 0);
        end
        chk("full_ready", issue_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        tick();
        chk("full_ready_hold", issue_ready, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'(10 * i), 5'(i));
        tick();
        chk("drained_ready", issue_ready, 1'b1);
        chk("drained_busy", busy, 1'b0);

        // Simultaneous grant and response with three outstanding.
        for (int i = 11; i <= 13; i++) begin
            issue(5'(i), 6'd4, mk_ops(i, 0, 0), 15'h0);
            cycle(1'b1, 1'b0, 0, 0);
        end
        issue(5'd14, 6'd4, mk_ops(14, 0, 0), 15'h0);
        cycle(1'b1, 1'b1, 32'h100, 5'h1);
        chk("simul_ready", issue_ready, 1'b1);
        chk("simul_busy", busy, 1'b1);
        issue(5'd15, 6'd4, mk_ops(15, 0, 0), 15'h0);
        cycle(1'b1, 1'b0, 0, 0);
        chk("simul_full", issue_ready, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h200 + 32'(i), 5'(i));
        tick();
        chk("simul_busy_done", busy, 1'b0);

        // Pointer wraparound with overlapping grant/response.
        for (int i = 0; i < 8; i++) begin
            issue(5'(16 + i), 6'd5, mk_ops(i, i + 1, i + 2), 15'(i));
            cycle(1'b1, (i >= 2), 32'h300 + 32'(i), 5'(i + 3));
        end
        cycle(1'b0, 1'b1, 32'h400, 5'h1E);
        cycle(1'b0, 1'b1, 32'h401, 5'h1F);
        tick();
        chk("wrap_busy_done", busy, 1'b0);
        chk("wrap_sb_drained", sb.size(), 0);

        // Spurious response.
        cycle(1'b0, 1'b1, 32'h55, 5'h0);
        chk("spur_set", spurious, exp_spur);
        tick();
        tick();
        chk("spur_hold", spurious, exp_spur);
        chk("spur_no_wb", wb_valid, 1'b0);
        do_reset();

        // Reset while a request is pending with two outstanding.
        for (int i = 1; i <= 2; i++) begin
            issue(5'(i), 6'd6, mk_ops(i, 0, 0), 15'h0);
            cycle(1'b1, 1'b0, 0, 0);
        end
        issue(5'd3, 6'd6, mk_ops(3, 0, 0), 15'h0);
        rst_n = 1'b0;
        tick();
        chk("midrst_req", apu_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tags.delete();
        in_req   = 1'b0;
        exp_spur = 1'b0;
        tick();
        cycle(1'b0, 1'b1, 32'h77, 5'h2);
        chk("midrst_spur", spurious, exp_spur);
        chk("midrst_no_wb", wb_valid, 1'b0);
        tick();
        chk("final_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
